// File: rtl/logic_gates_bist.sv
// Built-in self-test controller for the 2-input gate block: walks {a,b} through 00..11,
// checks all seven gate outputs per vector. Optional LGBIST_LOOP_EN adds continuous looping.
module logic_gates_bist #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
`ifdef LGBIST_LOOP_EN
    input  logic       loop_i,
`endif
    output logic       a_o,
    output logic       b_o,
    input  logic       and_i,
    input  logic       or_i,
    input  logic       not_i,
    input  logic       nand_i,
    input  logic       nor_i,
    input  logic       xor_i,
    input  logic       xnor_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_vec,
    output logic [2:0] err_count,
    output logic [1:0] first_fail
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    state_e     state_q;
    logic [1:0] idx_q;
    logic [3:0] cnt_q;
    logic       a_q, b_q, busy_q, done_q, pass_q;
    logic [6:0] fail_q;
    logic [2:0] err_q;
    logic [1:0] first_q;

    logic [6:0] exp_w, obs_w, mism_w;
    logic       launch_w, clear_w;

    // Bit order matches fail_vec: and, or, not, nand, nor, xor, xnor.
    always_comb begin
        exp_w  = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q), ~a_q, a_q | b_q, a_q & b_q};
        obs_w  = {xnor_i, xor_i, nor_i, nand_i, not_i, or_i, and_i};
        mism_w = exp_w ^ obs_w;
    end

    // A start request clears results; a loop restart keeps them accumulating.
    always_comb begin
        launch_w = 1'b0;
        clear_w  = 1'b0;
        if (state_q == IDLE || state_q == DONE) begin
            if (start) begin
                launch_w = 1'b1;
                clear_w  = 1'b1;
            end
`ifdef LGBIST_LOOP_EN
            else if (state_q == DONE && loop_i) begin
                launch_w = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
        end else if (launch_w) begin
            state_q <= SETTLE;
            idx_q   <= '0;
            cnt_q   <= RELOAD;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            if (clear_w) begin
                fail_q  <= '0;
                err_q   <= '0;
                first_q <= '0;
            end
        end else begin
            case (state_q)
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                CHECK: begin
                    fail_q <= fail_q | mism_w;
                    if (|mism_w) begin
                        // Saturation only matters when looping; a single run tops out at 4.
                        if (err_q != 3'd7) begin
                            err_q <= err_q + 3'd1;
                        end
                        if (err_q == '0) begin
                            first_q <= idx_q;
                        end
                    end
                    if (idx_q != 2'd3) begin
                        idx_q      <= idx_q + 2'd1;
                        {a_q, b_q} <= idx_q + 2'd1;
                        cnt_q      <= RELOAD;
                        state_q    <= SETTLE;
                    end else begin
                        state_q <= DONE;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= ((fail_q | mism_w) == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign a_o        = a_q;
    assign b_o        = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_vec   = fail_q;
    assign err_count  = err_q;
    assign first_fail = first_q;

endmodule

// File: tb/tb_logic_gates_bist.sv
// Directed bench for logic_gates_bist: good and faulty gate models, async reset, held start,
// and (with LGBIST_LOOP_EN) continuous looping.
module tb_logic_gates_bist;

    logic       clk = 1'b0;
    logic       rst_n, start;
`ifdef LGBIST_LOOP_EN
    logic       loop_i;
`endif
    logic       a_o, b_o;
    logic       and_i, or_i, not_i, nand_i, nor_i, xor_i, xnor_i;
    logic       busy, done, pass;
    logic [6:0] fail_vec;
    logic [2:0] err_count;
    logic [1:0] first_fail;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          fault_mode = 0;   // 0 good, 1 xor stuck 0, 2 not wired to b, 3 xnor stuck 1

    always #5 clk = ~clk;

    assign and_i  = a_o & b_o;
    assign or_i   = a_o | b_o;
    assign not_i  = (fault_mode == 2) ? b_o : ~a_o;
    assign nand_i = ~(a_o & b_o);
    assign nor_i  = ~(a_o | b_o);
    assign xor_i  = (fault_mode == 1) ? 1'b0 : (a_o ^ b_o);
    assign xnor_i = (fault_mode == 3) ? 1'b1 : ~(a_o ^ b_o);

    logic_gates_bist #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef LGBIST_LOOP_EN
        .loop_i(loop_i),
`endif
        .a_o(a_o), .b_o(b_o),
        .and_i(and_i), .or_i(or_i), .not_i(not_i), .nand_i(nand_i),
        .nor_i(nor_i), .xor_i(xor_i), .xnor_i(xnor_i),
        .busy(busy), .done(done), .pass(pass),
        .fail_vec(fail_vec), .err_count(err_count), .first_fail(first_fail)
    );

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the falling edge right after the start edge.
    task automatic launch(input bit hold);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Vector k/3 is applied for edges 0..11 after start; done rises at edge 12.
    task automatic track(input string tag);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            chk({tag, "_seq"}, {a_o, b_o, busy, done}, {2'(k / 3), 1'b1, 1'b0});
        end
        @(negedge clk);
        chk({tag, "_lat"}, {a_o, b_o, busy, done}, 4'b0001);
    endtask

    task automatic results(input string tag, input logic p, input logic [6:0] fv,
                           input logic [2:0] ec, input logic [1:0] ff);
        chk({tag, "_res"}, {a_o, b_o, busy, done, pass, fail_vec, err_count, first_fail},
            {1'b0, 1'b0, 1'b0, 1'b1, p, fv, ec, ff});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
`ifdef LGBIST_LOOP_EN
        loop_i = 1'b0;
`endif
        #12;
        chk("reset", {a_o, b_o, busy, done, pass, fail_vec, err_count, first_fail}, '0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("idle_hold", {busy, done, pass}, '0);

        // Good model
        launch(0);
        track("good");
        results("good", 1'b1, 7'b0000000, 3'd0, 2'b00);
        @(negedge clk);
        results("good_hold", 1'b1, 7'b0000000, 3'd0, 2'b00);

        // xor stuck at 0: fails on 01 and 10
        fault_mode = 1;
        launch(0);
        chk("xor_clr", {done, pass, fail_vec, err_count, first_fail}, '0);
        track("xor");
        results("xor", 1'b0, 7'b0100000, 3'd2, 2'b01);

        // not wired to b: fails on 00 and 11
        fault_mode = 2;
        launch(0);
        chk("not_clr", {done, pass, fail_vec, err_count, first_fail}, '0);
        track("not");
        results("not", 1'b0, 7'b0000100, 3'd2, 2'b00);

        // Async reset during vector 2
        fault_mode = 1;
        launch(0);
        repeat (6) @(negedge clk);
        chk("pre_rst", {a_o, b_o, busy, fail_vec, err_count, first_fail},
            {2'b10, 1'b1, 7'b0100000, 3'd1, 2'b01});
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst", {a_o, b_o, busy, done, pass, fail_vec, err_count, first_fail}, '0);
        @(negedge clk) rst_n = 1'b1;
        fault_mode = 0;
        launch(0);
        track("post_rst");
        results("post_rst", 1'b1, 7'b0000000, 3'd0, 2'b00);

        // Start held high: no mid-run restart, immediate restart from DONE clears results
        fault_mode = 1;
        launch(1);
        track("held");
        results("held", 1'b0, 7'b0100000, 3'd2, 2'b01);
        fault_mode = 0;
        @(negedge clk);
        chk("held_restart", {busy, done, pass, fail_vec, err_count}, {1'b1, 1'b0, 1'b0, 7'b0, 3'd0});
        start = 1'b0;
        track("held2");
        results("held2", 1'b1, 7'b0000000, 3'd0, 2'b00);

`ifdef LGBIST_LOOP_EN
        // xnor stuck at 1 with looping: 2 errors per loop, saturating at 7
        begin
            logic [2:0] exp_err [5] = '{3'd2, 3'd4, 3'd6, 3'd7, 3'd7};
            fault_mode = 3;
            loop_i = 1'b1;
            launch(0);
            repeat (12) @(negedge clk);
            for (int l = 0; l < 5; l++) begin
                chk("loop_done", {done, busy, pass, fail_vec, err_count, first_fail},
                    {1'b1, 1'b0, 1'b0, 7'b1000000, exp_err[l], 2'b01});
                @(negedge clk);
                chk("loop_pulse", {done, busy, pass}, {1'b0, 1'b1, 1'b0});
                repeat (12) @(negedge clk);
            end
            loop_i = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
